// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM encoding,
// wait-counter width and default bus geometry.
package dmem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;

    localparam logic [7:0] IO_ADDR_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the control unit (master) and the
// data-memory responder (slave).
interface dmem_if import dmem_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dmem_array.sv
// 2^ADDR_W x DATA_W storage with synchronous write and synchronous,
// enable-gated read; the read register holds between reads.
module dmem_array import dmem_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // NOTE: storage is deliberately left out of reset; the declaration
    // initialiser supplies the all-zero power-up contents instead.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_q = '0;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// one-cycle response pulse, and a single I/O byte mapped at IO_ADDR.
module dmem_responder import dmem_pkg::*; #(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    dmem_if.slave             bus,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out
);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_q;
    logic              from_mem_q;
    logic [DATA_W-1:0] io_out_q;

    logic              is_io;
    logic              access;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    assign is_io  = (addr_q == IO_ADDR);
    assign access = (state_q == ST_BUSY) && (cnt_q == '0);
    // Reset on the access edge wins, so the array must not commit then.
    assign mem_we = access && write_q && !is_io && !reset;
    assign mem_re = access && !write_q && !is_io && !reset;
    assign cnt_d  = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

    dmem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            from_mem_q  <= 1'b0;
            io_out_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // NOTE: the request latches need no reset; they are only
                    // read after an accept has loaded them.
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        write_q <= bus.req_write;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        ready_q <= 1'b0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_d;
                    if (access) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                        if (write_q) begin
                            rsp_q      <= wdata_q;
                            from_mem_q <= 1'b0;
                            if (is_io) begin
                                io_out_q <= wdata_q;
                            end
                        end else if (is_io) begin
                            rsp_q      <= io_in;
                            from_mem_q <= 1'b0;
                        end else begin
                            from_mem_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = from_mem_q ? mem_rdata : rsp_q;
    assign io_out        = io_out_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the control unit's data-memory load/store requests.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Returns read data, or a write acknowledge, with a one-cycle rsp_valid pulse.
- Provides one memory-mapped I/O byte (io_out register and io_in input) at IO_ADDR; all other addresses map to a 256x8 data array.

Parameters:
- ADDR_W, 8, request address width.
- DATA_W, 8, data width.
- WAIT_CYCLES, 1, extra BUSY cycles before the array access; legal range 0..15.
- IO_ADDR, 8'hFF, address decoded as the I/O byte instead of the array.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  responder can accept a request (high only in IDLE).
- rsp_valid  out  1  one-cycle response or acknowledge pulse.
- rsp_rdata  out  DATA_W  load data, or echoed store data on writes.
- io_in  in  DATA_W  value returned on loads from IO_ADDR.
- io_out  out  DATA_W  register written by stores to IO_ADDR.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On a reset edge:
  - state = IDLE, cnt = 0, rsp_valid = 0, rsp_rdata = 0, io_out = 0.
  - req_ready = 1 from the first cycle after reset.
  - Array contents are not cleared by reset; they initialise to zero at simulation time 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1 (accept edge E0): latch addr, wdata and write; load cnt = WAIT_CYCLES; go to BUSY.
- BUSY:
  - req_ready = 0.
  - Each edge with cnt != 0: cnt decrements.
  - Edge with cnt == 0 (the access edge): perform the access, then go to RESP.
  - Store, addr == IO_ADDR: io_out <= wdata; array untouched.
  - Store, other addr: mem[addr] <= wdata.
  - All stores: rsp_rdata <= wdata.
  - Load, addr == IO_ADDR: rsp_rdata <= io_in, sampled at the access edge.
  - Load, other addr: rsp_rdata <= mem[addr].
- RESP:
  - rsp_valid = 1 for exactly this one cycle; req_ready = 0.
  - Next edge: go to IDLE. rsp_valid returns to 0; rsp_rdata holds its value until the next access edge.
- Latency: rsp_valid is high in the cycle after edge E0 + WAIT_CYCLES + 1.
  - Default (WAIT_CYCLES = 1): the cycle after E0 + 2.
  - Minimum spacing between accept edges is WAIT_CYCLES + 3 edges.
- Handshake rules:
  - Request inputs are sampled only at the accept edge; later changes are ignored.
  - req_valid outside IDLE is ignored; the requester holds the request until it is accepted.
  - No response is issued without a prior accept.
- Address arithmetic: addresses are 8-bit absolute. Requester-side address arithmetic wraps modulo 256; the responder performs no arithmetic on addresses.
- Reset mid-operation:
  - A transaction in BUSY is dropped. A store not yet at its access edge is not committed, and no rsp_valid is issued.
  - Reset in the RESP cycle clears rsp_valid on that edge; a store already committed remains in the array.
- Reset and req_valid on the same edge: reset wins; the request is not accepted.
- Loading the same address as the immediately preceding store returns the new data (no hazard, since accesses are serialised).

Decomposition:
- Shared package dmem_pkg: state encodings (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2), default IO_ADDR, counter width (4 bits), DATA_W and ADDR_W defaults.
- Sub-module dmem_array: 2^ADDR_W x DATA_W storage with synchronous write (we, addr, wdata) and synchronous read (re, addr, rdata), zero-initialised.
- dmem_responder contains the FSM, wait counter, I/O decode and response register.

Test Plan:
- Reset, then store 0x5A to 0x10, then load 0x10 -> each rsp_valid is high in the cycle after E0 + 2 for exactly one cycle; load rsp_rdata = 0x5A; store rsp_rdata = 0x5A.
- Store 0xC3 to 0xFF -> io_out = 0xC3 after the access edge and mem[0xFF] unchanged; then load 0xFF with io_in = 0x77 -> rsp_rdata = 0x77.
- Accept a load of 0x20, then drive req_valid with addr 0x30 through BUSY and RESP -> req_ready = 0 and no second accept; the 0x30 request is accepted on the first IDLE edge, with exactly one rsp_valid per request.
- Store 0x99 to 0x40, with reset asserted during BUSY before the access edge -> no rsp_valid; a later load of 0x40 returns 0x00.
- Instance with WAIT_CYCLES = 0 -> rsp_valid in the cycle after E0 + 1; instance with WAIT_CYCLES = 3 -> rsp_valid in the cycle after E0 + 4.
- Back-to-back stores of 0x01 to 0xFE and 0x02 to 0x00, then loads of both -> 0x01 and 0x02 returned; io_out stays 0x00.
